// File: rtl/vdp_pkg.sv
// Shared types and constants for the VDP VRAM-to-BRAM bridge.
package vdp_pkg;

  localparam int VRAM_AW = 15;
  localparam int BRAM_AW = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR    = 3'd1,
    RD    = 3'd2,
    RDOUT = 3'd3,
    ACK   = 3'd4
  } vram_br_state_t;

endpackage

// File: rtl/vram_bram_bridge.sv
// VDP 16-bit VRAM bus to a pair of 8-bit BRAM ports (A = high byte,
// B = low byte). One request is served per visit to IDLE; DTACK_N is held
// low in ACK until the VDP releases VRAM_SEL.
// Build option: define VRAM_BRIDGE_OUTREG_EN to put one extra register
// stage on read data (RD -> RDOUT -> ACK, one more clock of read latency).
module vram_bram_bridge
  import vdp_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               VRAM_SEL,
  input  logic               VRAM_CE_N,
  input  logic               VRAM_OE_N,
  input  logic               VRAM_WE_N,
  input  logic               VRAM_UB_N,
  input  logic               VRAM_LB_N,
  input  logic [VRAM_AW-1:0] VRAM_ADDR,
  input  logic [15:0]        VRAM_DI,
  output logic [15:0]        VRAM_DO,
  output logic               VRAM_DTACK_N,
  output logic [BRAM_AW-1:0] BRAM_ADDRA,
  output logic [BRAM_AW-1:0] BRAM_ADDRB,
  output logic               BRAM_ENA,
  output logic               BRAM_WEA,
  output logic               BRAM_ENB,
  output logic               BRAM_WEB,
  output logic [7:0]         BRAM_DINA,
  output logic [7:0]         BRAM_DINB,
  input  logic [7:0]         BRAM_DOUTA,
  input  logic [7:0]         BRAM_DOUTB
);

  vram_br_state_t state, nstate;

  logic [1:0]         cnt;
  logic [VRAM_AW-1:0] addr_q;
  logic               ub_q, lb_q;     // lane enables, active high
  logic [15:0]        di_q;
  logic               abort_q;        // VDP let go of SEL mid-access

  logic        req, last_rd, stop, wr_cyc, rd_first;
  logic [15:0] rd_word;

  assign req      = VRAM_SEL & ~VRAM_CE_N;
  assign last_rd  = (cnt == 2'(RD_LAT - 1));
  // Abort takes effect even if SEL drops right on the deciding edge.
  assign stop     = abort_q | ~VRAM_SEL;
  assign wr_cyc   = (state == WR);
  assign rd_first = (state == RD) && (cnt == 2'd0);
  // Disabled lanes read as zero.
  assign rd_word  = {ub_q ? BRAM_DOUTA : 8'h00, lb_q ? BRAM_DOUTB : 8'h00};

  // State register, read-latency counter and abort flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      cnt     <= 2'd0;
      abort_q <= 1'b0;
    end else begin
      state   <= nstate;
      cnt     <= (state == RD && !last_rd) ? cnt + 2'd1 : 2'd0;
      if (state == IDLE)
        abort_q <= 1'b0;
      else if ((state == WR || state == RD || state == RDOUT) && !VRAM_SEL)
        abort_q <= 1'b1;
    end
  end

  // Next-state decode; an aborted access still completes its BRAM cycle
  // and then drops back to IDLE without acknowledging.
  always_comb begin
    nstate = state;
    case (state)
      IDLE: begin
        if (req) begin
          if (!VRAM_WE_N)      nstate = WR;
          else if (!VRAM_OE_N) nstate = RD;
          else                 nstate = ACK;
        end
      end
      WR: nstate = stop ? IDLE : ACK;
      RD: begin
        if (last_rd) begin
`ifdef VRAM_BRIDGE_OUTREG_EN
          nstate = stop ? IDLE : RDOUT;
`else
          nstate = stop ? IDLE : ACK;
`endif
        end
      end
      RDOUT: nstate = stop ? IDLE : ACK;
      ACK:   if (!VRAM_SEL) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Request latch on acceptance in IDLE.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      addr_q <= '0;
      ub_q   <= 1'b0;
      lb_q   <= 1'b0;
      di_q   <= 16'h0000;
    end else if (state == IDLE && req) begin
      addr_q <= VRAM_ADDR;
      ub_q   <= ~VRAM_UB_N;
      lb_q   <= ~VRAM_LB_N;
      di_q   <= VRAM_DI;
    end
  end

`ifdef VRAM_BRIDGE_OUTREG_EN
  logic [15:0] rd_q;

  // Read data lands in the staging register, then moves to VRAM_DO in RDOUT.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_q    <= 16'h0000;
      VRAM_DO <= 16'h0000;
    end else begin
      if (state == RD && last_rd && !stop) rd_q <= rd_word;
      if (state == RDOUT && !stop)         VRAM_DO <= rd_q;
    end
  end
`else
  // Read data captured straight into VRAM_DO on the last latency edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      VRAM_DO <= 16'h0000;
    else if (state == RD && last_rd && !stop)
      VRAM_DO <= rd_word;
  end
`endif

  // BRAM strobes decoded from state so they drop the instant state leaves
  // WR / first RD cycle (including asynchronous reset); addresses are held.
  always_comb begin
    BRAM_ADDRA   = {addr_q, 1'b0};
    BRAM_ADDRB   = {addr_q, 1'b1};
    BRAM_ENA     = (wr_cyc | rd_first) & ub_q;
    BRAM_ENB     = (wr_cyc | rd_first) & lb_q;
    BRAM_WEA     = wr_cyc & ub_q;
    BRAM_WEB     = wr_cyc & lb_q;
    BRAM_DINA    = wr_cyc ? di_q[15:8] : 8'h00;
    BRAM_DINB    = wr_cyc ? di_q[7:0]  : 8'h00;
    VRAM_DTACK_N = (state != ACK);
  end

endmodule
